// File: rtl/serial_tx_shifter.sv
// Parallel-to-serial frame transmitter: start(0), DATA_W bits LSB first, [parity], stop(1).
// Define SERIAL_TX_PARITY_EN to insert an even-parity bit between data and stop.
//
// state  | meaning
// IDLE   | line high, ready for a load
// START  | start bit (0)
// DATA   | payload bits, LSB first
// PARITY | even parity of latched word (SERIAL_TX_PARITY_EN only)
// STOP   | stop bit (1), done on its last cycle
module serial_tx_shifter #(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] data_in,
  input  logic              load,
  output logic              ready,
  output logic              tx,
  output logic              busy,
  output logic              done
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_W - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    STOP   = 3'd3
`ifdef SERIAL_TX_PARITY_EN
    ,PARITY = 3'd4
`endif
  } state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [BW-1:0]     bit_q, bit_d;
  logic [CW-1:0]     baud_q, baud_d;
  logic              tx_q, tx_d;
  logic              bit_end;
  logic              accept;
`ifdef SERIAL_TX_PARITY_EN
  logic              parity_q;
`endif

  assign bit_end = (baud_q == BAUD_LAST);

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    bit_d   = bit_q;
    baud_d  = baud_q;
    accept  = 1'b0;
    tx_d    = 1'b1;

    if (state_q != IDLE) begin
      baud_d = bit_end ? '0 : baud_q + CW'(1);
    end

    case (state_q)
      IDLE: begin
        if (load) begin
          accept  = 1'b1;
          state_d = START;
          shift_d = data_in;
          bit_d   = '0;
          baud_d  = '0;
        end
      end
      START: if (bit_end) state_d = DATA;
      DATA: begin
        if (bit_end) begin
          shift_d = shift_q >> 1;
          if (bit_q == BIT_LAST) begin
            bit_d = '0;
`ifdef SERIAL_TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            bit_d = bit_q + BW'(1);
          end
        end
      end
`ifdef SERIAL_TX_PARITY_EN
      PARITY: if (bit_end) state_d = STOP;
`endif
      STOP: if (bit_end) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // tx is registered from the next state so the pin never glitches
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
`ifdef SERIAL_TX_PARITY_EN
      PARITY:  tx_d = parity_q;
`endif
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      shift_q <= '0;
      bit_q   <= '0;
      baud_q  <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      bit_q   <= bit_d;
      baud_q  <= baud_d;
      tx_q    <= tx_d;
    end
  end

`ifdef SERIAL_TX_PARITY_EN
  always_ff @(posedge clk) begin
    if (reset)       parity_q <= 1'b0;
    else if (accept) parity_q <= ^data_in;
  end
`endif

  assign tx    = tx_q;
  assign ready = (state_q == IDLE);
  assign busy  = (state_q != IDLE);
  assign done  = (state_q == STOP) && bit_end;

endmodule
